serial_frame_tx: RTL
====================

// Module: serial_frame_tx
// PURPOSE
//   Serial frame transmitter: accepts a WIDTH-bit word over a valid/ready handshake and
//   drives it onto a single line as start bit, data LSB first, optional parity bit, stop bit.
//   Transmit end of the serial link; the sampling/receive end is built from the DFF/latch
//   primitives. Line idles high. Fully synchronous to clk.
// PARAMETERS
//   WIDTH         8   data bits per frame, >=1
//   CLKS_PER_BIT  4   clk cycles each line bit is held, >=1 (1 is legal)
//   PARITY_EN     1   1 = parity bit inserted after data; 0 = no parity bit
//   PARITY_ODD    0   1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
// PORTS
//   clk         in   1      clock; all state updates on rising edge
//   rst_n       in   1      synchronous reset, active low
//   tx_data     in   WIDTH  word to send; sampled only on handshake
//   tx_valid    in   1      tx_data valid
//   tx_ready    out  1      block can accept a word this cycle
//   tx_out      out  1      serial line, idle high
//   tx_busy     out  1      frame in progress (START..STOP)
//   frame_done  out  1      one-cycle pulse in the final cycle of the stop bit
// BEHAVIOUR
//   Reset (rst_n low at rising edge): state IDLE, tx_out=1, tx_ready=1, tx_busy=0,
//     frame_done=0, bit/cycle counters=0. Reset mid-frame abandons it, no frame_done.
//   Handshake: word accepted at rising edge where tx_valid & tx_ready; tx_data captured
//     into internal shift register; later tx_data changes have no effect.
//     tx_valid while tx_ready=0 ignored, never queued.
//   tx_ready = (state==IDLE) | (state==STOP & last cycle of stop bit).
//   States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE/START.
//     IDLE: tx_out=1; on accept -> START.
//     START: tx_out=0 for CLKS_PER_BIT cycles -> DATA.
//     DATA: tx_out=shreg[0]; shift right every CLKS_PER_BIT cycles; after WIDTH bits
//       -> PARITY (PARITY_EN=1) else STOP.
//     PARITY: tx_out = ^data_captured ^ PARITY_ODD, CLKS_PER_BIT cycles -> STOP.
//     STOP: tx_out=1 for CLKS_PER_BIT cycles; last cycle: frame_done=1, tx_ready=1;
//       accept that edge -> START (no idle gap), else -> IDLE.
//   Latency: tx_out drops first cycle after accepting edge. Frame length
//     (2+WIDTH+PARITY_EN)*CLKS_PER_BIT cycles; frame_done in its last cycle.
//   tx_busy=1 in START/DATA/PARITY/STOP, 0 in IDLE.
//   Counters: cycle counter $clog2(CLKS_PER_BIT) bits (min 1), wraps to 0 at each bit
//     boundary; bit counter $clog2(WIDTH+1) bits, cleared on every accept.
//   Outputs registered or decoded from registered state; no comb path from
//     tx_valid/tx_data to tx_out.
// TESTING
//   T1 rst_n low 3 cycles, tx_valid=1 -> tx_out=1, tx_ready=1, tx_busy=0, frame_done=0.
//   T2 defaults, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,P=0,1, 4 cycles each; frame_done
//      in cycle 44 after accept; tx_ready back high that cycle.
//   T3 tx_valid held, 0x01 then 0xFF -> second start bit directly after first stop bit,
//      parity 1 then 0, two frame_done pulses 44 cycles apart.
//   T4 0x3C accepted, tx_data to 0xFF and tx_valid pulsed mid-frame -> line still
//      carries 0x3C, no second frame, tx_ready low until last stop cycle.
//   T5 rst_n low for 1 edge during 3rd data bit -> tx_out=1, tx_ready=1, tx_busy=0
//      next cycle; no frame_done; next word sent as clean full frame.
//   T6 PARITY_ODD=1, CLKS_PER_BIT=1, send 0x00 -> 11-cycle frame, parity bit=1;
//      PARITY_EN=0 same word -> 10-cycle frame, no parity slot.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional parity, stop bit.
// All outputs are registered from the next-state values so nothing from tx_valid/tx_data reaches tx_out combinationally.
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_out,
  output logic             tx_busy,
  output logic             frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic frame_parity(input logic [WIDTH-1:0] data);
    frame_parity = (^data) ^ (PARITY_ODD != 0);
  endfunction

  state_t             state_r, state_s;
  logic [CW-1:0]      cyc_r, cyc_s;
  logic [BW-1:0]      bit_r, bit_s;
  logic [WIDTH-1:0]   shreg_r, shreg_s;
  logic               par_r, par_s;
  logic               tx_ready_r, tx_out_r, tx_busy_r, frame_done_r;
  logic               out_s, busy_s, ready_s, done_s;
  logic               accept_s, last_cyc_s;

  assign tx_ready   = tx_ready_r;
  assign tx_out     = tx_out_r;
  assign tx_busy    = tx_busy_r;
  assign frame_done = frame_done_r;

  // Next-state, next-counter and next-output decode
  always_comb begin
    state_s    = state_r;
    cyc_s      = cyc_r;
    bit_s      = bit_r;
    shreg_s    = shreg_r;
    par_s      = par_r;
    accept_s   = tx_valid & tx_ready_r;
    last_cyc_s = (cyc_r == LAST_CYC);

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (last_cyc_s) begin
          state_s = ST_DATA;
          cyc_s   = '0;
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      ST_DATA: begin
        if (last_cyc_s) begin
          cyc_s   = '0;
          shreg_s = shreg_r >> 1'b1;
          bit_s   = bit_r + BIT_ONE;
          if (bit_r == LAST_BIT) begin
            state_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      ST_PARITY: begin
        if (last_cyc_s) begin
          state_s = ST_STOP;
          cyc_s   = '0;
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      ST_STOP: begin
        if (last_cyc_s) begin
          // back-to-back frames: a word offered in the last stop cycle starts immediately
          state_s = accept_s ? ST_START : ST_IDLE;
          cyc_s   = '0;
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cyc_s   = '0;
        bit_s   = '0;
      end
    endcase

    if (accept_s) begin
      cyc_s   = '0;
      bit_s   = '0;
      shreg_s = tx_data;
      par_s   = frame_parity(tx_data);
    end else begin
      par_s = par_r;
    end

    done_s  = (state_s == ST_STOP) && (cyc_s == LAST_CYC);
    busy_s  = (state_s != ST_IDLE);
    ready_s = (state_s == ST_IDLE) || done_s;
    case (state_s)
      ST_IDLE:   out_s = 1'b1;
      ST_START:  out_s = 1'b0;
      ST_DATA:   out_s = shreg_s[0];
      ST_PARITY: out_s = par_s;
      ST_STOP:   out_s = 1'b1;
      default:   out_s = 1'b1;
    endcase
  end

  // State, datapath and registered output update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cyc_r        <= '0;
      bit_r        <= '0;
      shreg_r      <= '0;
      par_r        <= 1'b0;
      tx_out_r     <= 1'b1;
      tx_ready_r   <= 1'b1;
      tx_busy_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cyc_r        <= cyc_s;
      bit_r        <= bit_s;
      shreg_r      <= shreg_s;
      par_r        <= par_s;
      tx_out_r     <= out_s;
      tx_ready_r   <= ready_s;
      tx_busy_r    <= busy_s;
      frame_done_r <= done_s;
    end
  end

endmodule
